// File: rtl/ccff_chain_loader_if.sv
// Bitstream word handshake between fetch logic (master) and the chain loader (slave).
interface ccff_chain_loader_if #(
   parameter int WORD_W = 8
) ();
   logic [WORD_W-1:0] cfg_data;
   logic              cfg_valid;
   logic              cfg_ready;

   modport master (output cfg_data, output cfg_valid, input  cfg_ready);
   modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises bitstream words LSB-first onto a clb/fle ccff chain, gating config_enable per bit.
// Optional CCFF_READBACK_EN: shadow-models the chain and flags ccff_tail mismatches on reload.
module ccff_chain_loader #(
   parameter int CHAIN_LEN = 66,
   parameter int WORD_W    = 8
) (
   input  logic                 prog_clock,
   input  logic                 prog_reset,
   ccff_chain_loader_if.slave   cfg,
   input  logic                 start,
   input  logic                 abort,
   output logic                 config_enable,
   output logic                 ccff_head,
   input  logic                 ccff_tail,
   output logic                 busy,
   output logic                 done
`ifdef CCFF_READBACK_EN
   ,
   output logic                 readback_err
`endif
);

   localparam int RW = $clog2(CHAIN_LEN + 1);
   localparam int WB = $clog2(WORD_W + 1);
   localparam logic [RW-1:0] LEN_R  = RW'(CHAIN_LEN);
   localparam logic [WB-1:0] WORD_B = WB'(WORD_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_SHIFT,
      S_FINISH
   } state_t;

   state_t            r_state;
   logic [RW-1:0]     r_remaining;
   logic [WB-1:0]     r_word_bits;
   logic [WORD_W-1:0] r_shreg;
   logic              r_head;
   logic              r_cfg_en;
   logic              r_cfg_ready;
   logic              r_busy;
   logic              r_done;

   logic              w_cfg_ready;
   logic              w_hs;
   logic [WB-1:0]     w_first_bits;

   // abort gates the registered strobes combinationally so nothing shifts or handshakes that cycle
   assign w_cfg_ready   = r_cfg_ready & ~abort;
   assign cfg.cfg_ready = w_cfg_ready;
   assign w_hs          = cfg.cfg_valid & w_cfg_ready;
   assign config_enable = r_cfg_en & ~abort;
   assign ccff_head     = r_head;
   assign busy          = r_busy;
   assign done          = r_done & ~abort;

   always_comb begin
      w_first_bits = WORD_B;
      if (32'(r_remaining) < WORD_W) begin
         w_first_bits = WB'(r_remaining);
      end
   end

   always_ff @(posedge prog_clock or posedge prog_reset) begin
      if (prog_reset) begin
         r_state     <= S_IDLE;
         r_remaining <= '0;
         r_word_bits <= '0;
         r_shreg     <= '0;
         r_head      <= 1'b0;
         r_cfg_en    <= 1'b0;
         r_cfg_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state     <= S_FETCH;
                  r_remaining <= LEN_R;
                  r_cfg_ready <= 1'b1;
                  r_busy      <= 1'b1;
               end
            end
            S_FETCH: begin
               if (abort) begin
                  r_state     <= S_IDLE;
                  r_cfg_ready <= 1'b0;
                  r_cfg_en    <= 1'b0;
                  r_busy      <= 1'b0;
               end else if (w_hs) begin
                  r_head      <= cfg.cfg_data[0];
                  r_shreg     <= cfg.cfg_data >> 1;
                  r_word_bits <= w_first_bits;
                  r_cfg_ready <= 1'b0;
                  r_cfg_en    <= 1'b1;
                  r_state     <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (abort) begin
                  r_state     <= S_IDLE;
                  r_cfg_ready <= 1'b0;
                  r_cfg_en    <= 1'b0;
                  r_busy      <= 1'b0;
               end else begin
                  r_remaining <= r_remaining - 1'b1;
                  r_word_bits <= r_word_bits - 1'b1;
                  // head holds the last shifted bit whenever the shift stops
                  if (r_remaining == RW'(1)) begin
                     r_state  <= S_FINISH;
                     r_cfg_en <= 1'b0;
                     r_done   <= 1'b1;
                  end else if (r_word_bits == WB'(1)) begin
                     r_state     <= S_FETCH;
                     r_cfg_en    <= 1'b0;
                     r_cfg_ready <= 1'b1;
                  end else begin
                     r_head  <= r_shreg[0];
                     r_shreg <= r_shreg >> 1;
                  end
               end
            end
            S_FINISH: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_cfg_en    <= 1'b0;
               r_cfg_ready <= 1'b0;
            end
            default: begin
               r_state     <= S_IDLE;
               r_busy      <= 1'b0;
               r_cfg_en    <= 1'b0;
               r_cfg_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef CCFF_READBACK_EN
   logic [CHAIN_LEN-1:0] r_shadow;
   logic                 r_shadow_vld;
   logic                 r_readback_err;

   assign readback_err = r_readback_err;

   // shadow only becomes trustworthy once a complete load has gone through it
   always_ff @(posedge prog_clock or posedge prog_reset) begin
      if (prog_reset) begin
         r_shadow       <= '0;
         r_shadow_vld   <= 1'b0;
         r_readback_err <= 1'b0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_readback_err <= 1'b0;
         end
         if (config_enable) begin
            if (r_shadow_vld && (ccff_tail != r_shadow[CHAIN_LEN-1])) begin
               r_readback_err <= 1'b1;
            end
            r_shadow <= CHAIN_LEN'({r_shadow, ccff_head});
         end
         if (abort && r_state != S_IDLE) begin
            r_shadow_vld <= 1'b0;
         end else if (r_state == S_FINISH) begin
            r_shadow_vld <= 1'b1;
         end
      end
   end
`else
   logic w_tail_unused;
   assign w_tail_unused = ccff_tail;
`endif

endmodule
